// File: rtl/sched_dp_pkg.sv
// Shared types and constants for the scheduled-datapath driver,
// controller and datapath.
package sched_dp_pkg;

  localparam int N_OPERANDS = 8;
  localparam int SCHED_LAT  = 4;
  localparam int W_DEF      = 8;
  localparam int RES_W_DEF  = W_DEF + 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RUN,
    CAPTURE
  } state_e;

endpackage

// File: rtl/sched_result_fifo.sv
// Show-ahead result FIFO between the driver and the downstream consumer.
// Head reads as zero while the FIFO is empty.
module sched_result_fifo
  import sched_dp_pkg::*;
#(
  parameter int RES_W = RES_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [RES_W-1:0]         din_i,
  input  logic                     pop_i,
  output logic [RES_W-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [RES_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is only legal alongside a pop.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/sched_dp_driver.sv
// Job initiator for one scheduled controller+datapath pair: issues start,
// captures results on done_next and queues them for the consumer.
module sched_dp_driver
  import sched_dp_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_OPERANDS*W-1:0] in_data,
  input  logic                    op_ready,
  output logic                    start,
  input  logic                    result_en,
  input  logic                    done_next,
  output logic [N_OPERANDS*W-1:0] dp_operands,
  input  logic [RES_W-1:0]        dp_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RES_W-1:0]        out_data,
  output logic                    busy,
  output logic                    err_timeout,
  output logic [15:0]             job_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                  state_q;
  logic [N_OPERANDS*W-1:0] ops_q;
  logic [TW-1:0]           tcnt_q;
  logic                    seen_q;
  logic                    err_q;
  logic [15:0]             jobs_q;

  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [$clog2(DEPTH):0]  count;

  assign in_ready    = ~rst & (state_q == IDLE) & ~full;
  assign start       = ~rst & (state_q == ISSUE) & op_ready;
  assign busy        = (state_q != IDLE);
  assign dp_operands = ops_q;
  assign err_timeout = err_q;
  assign job_count   = jobs_q;
  assign out_valid   = ~empty;
  assign push        = (state_q == RUN) & done_next;
  assign pop         = out_ready & out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ops_q   <= '0;
      tcnt_q  <= '0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
      jobs_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            ops_q   <= in_data;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (op_ready) begin
            tcnt_q  <= '0;
            seen_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          seen_q <= seen_q | result_en;
          tcnt_q <= tcnt_q + 1'b1;
          if (done_next) begin
            jobs_q  <= jobs_q + 16'd1;
            state_q <= CAPTURE;
          end else if (tcnt_q == TW'(TIMEOUT - 2)) begin
            // Counter reaches TIMEOUT-1 on this edge: abandon the job.
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        CAPTURE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  sched_result_fifo #(
    .RES_W (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (dp_result),
    .pop_i   (pop),
    .head_o  (out_data),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_sched_dp_driver.sv
// Directed bench for sched_dp_driver with an add-tree controller model.
module tb_sched_dp_driver;

  localparam int W = 8;
  localparam int RES_W = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [8*W-1:0]    in_data;
  logic              op_ready;
  logic              start;
  logic              result_en;
  logic              done_next;
  logic [8*W-1:0]    dp_operands;
  logic [RES_W-1:0]  dp_result;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_data;
  logic              busy;
  logic              err_timeout;
  logic [15:0]       job_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_jobs = 0;

  logic       stall;
  logic       no_done;
  logic [2:0] ph;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sched_dp_driver dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .op_ready    (op_ready),
    .start       (start),
    .result_en   (result_en),
    .done_next   (done_next),
    .dp_operands (dp_operands),
    .dp_result   (dp_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .err_timeout (err_timeout),
    .job_count   (job_count)
  );

  function automatic logic [RES_W-1:0] add8(input logic [8*W-1:0] v);
    logic [RES_W-1:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + RES_W'(v[k*W +: W]);
    return s;
  endfunction

  // Reference controller: start at t, result_en t+3, done_next t+4,
  // op_ready back at t+5.
  assign op_ready  = (ph == 3'd0) && !stall;
  assign result_en = (ph == 3'd3);
  assign done_next = (ph == 3'd4) && !no_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph        <= 3'd0;
      dp_result <= '0;
    end else begin
      if (start) ph <= 3'd1;
      else if (ph == 3'd4) ph <= 3'd0;
      else if (ph != 3'd0) ph <= ph + 3'd1;
      if (result_en) dp_result <= add8(dp_operands);
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) @cyc %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic submit(input logic [8*W-1:0] ops);
    int n;
    @(negedge clk);
    in_data  = ops;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_start(output int t);
    int n;
    n = 0;
    while (!start && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!start) chk("start_wait", 0, 1);
    t = cyc;
  endtask

  task automatic wait_out(output int t);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_wait", 0, 1);
    t = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_wait", 0, 1);
  endtask

  typedef struct {
    logic [8*W-1:0]   ops;
    logic [RES_W-1:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int t, to;
    int acc, nres, nst, last_st, min_sp, consec;
    logic prev_st;
    logic [7:0] b;
    logic [8*W-1:0] hold;

    vecs[0] = '{64'h0807060504030201, 11'd36};
    vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 11'd2040};
    vecs[2] = '{64'h0101010101010101, 11'd8};
    vecs[3] = '{64'h0000000000000000, 11'd0};
    vecs[4] = '{64'h50463C32281E140A, 11'd360};
    vecs[5] = '{64'h8000000000000000, 11'd128};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    stall = 1'b0; no_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_start", start, 0);
    chk("rst_ops", dp_operands, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_jobs", job_count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // Single jobs from the vector table
    foreach (vecs[i]) begin
      submit(vecs[i].ops);
      wait_start(t);
      chk("start_ops", dp_operands, vecs[i].ops);
      @(negedge clk);
      chk("start_pulse", start, 0);
      wait_out(to);
      chk("latency", to - t, 5);
      chk("result", out_data, vecs[i].exp);
      exp_jobs++;
      chk("jobs", job_count, exp_jobs);
      @(negedge clk);
      chk("popped", out_valid, 0);
    end

    // Back-to-back with in_valid held
    acc = 0; nres = 0; nst = 0; last_st = -100; min_sp = 1000;
    consec = 0; prev_st = 1'b0;
    in_data = 64'hFFFFFFFFFFFFFFFF;
    for (int n = 0; n < 80 && nres < 4; n++) begin
      @(negedge clk);
      in_valid = (acc < 4);
      if (in_valid && in_ready) acc++;
      if (start) begin
        if (prev_st) consec++;
        if (nst > 0 && cyc - last_st < min_sp) min_sp = cyc - last_st;
        last_st = cyc;
        nst++;
      end
      prev_st = start;
      if (out_valid) begin
        chk("b2b_result", out_data, 11'd2040);
        nres++;
      end
    end
    in_valid = 1'b0;
    exp_jobs += 4;
    chk("b2b_nres", nres, 4);
    chk("b2b_starts", nst, 4);
    chk("b2b_consec", consec, 0);
    chk("b2b_spacing_ge5", min_sp >= 5, 1);
    chk("b2b_jobs", job_count, exp_jobs);

    // Backpressure: fill the FIFO, then free one slot
    @(negedge clk);
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      b = 8'(j + 1);
      submit({8{b}});
      wait_idle();
    end
    @(negedge clk);
    exp_jobs += 4;
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_data, 8);
    b = 8'd5;
    in_data = {8{b}};
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_not_accepted", busy, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_in_ready_after_pop", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_5th_accepted", busy, 1);
    wait_idle();
    exp_jobs++;
    chk("bp_jobs", job_count, exp_jobs);
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_out(to);
      chk("bp_drain", out_data, 8 * (k + 2));
      @(negedge clk);
    end
    chk("bp_empty", out_valid, 0);

    // Timeout: done_next never arrives
    no_done = 1'b1;
    submit(64'h0807060504030201);
    wait_start(t);
    while (cyc < t + 15) @(negedge clk);
    chk("to_err_before", err_timeout, 0);
    chk("to_busy_before", busy, 1);
    @(negedge clk);
    chk("to_err_at", err_timeout, 1);
    chk("to_idle", busy, 0);
    chk("to_fifo_empty", out_valid, 0);
    chk("to_jobs", job_count, exp_jobs);
    no_done = 1'b0;
    repeat (2) @(negedge clk);
    submit(vecs[4].ops);
    wait_out(to);
    chk("to_next_result", out_data, 360);
    exp_jobs++;
    @(negedge clk);
    chk("to_next_jobs", job_count, exp_jobs);
    chk("to_err_sticky", err_timeout, 1);

    // Controller stall in ISSUE
    stall = 1'b1;
    hold = 64'h1122334455667788;
    submit(hold);
    for (int i = 0; i < 7; i++) begin
      chk("stall_start", start, 0);
      chk("stall_ops", dp_operands, hold);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    chk("stall_release_start", start, 1);
    @(negedge clk);
    chk("stall_start_drop", start, 0);
    chk("stall_ops_after", dp_operands, hold);
    wait_out(to);
    chk("stall_result", out_data, add8(hold));
    exp_jobs++;
    @(negedge clk);

    // Reset mid-job
    submit(vecs[1].ops);
    wait_start(t);
    while (cyc < t + 2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_start", start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_err", err_timeout, 0);
    chk("mid_rst_jobs", job_count, 0);
    @(negedge clk);
    rst = 1'b0;
    submit(vecs[2].ops);
    wait_out(to);
    chk("post_rst_result", out_data, 8);
    @(negedge clk);
    chk("post_rst_jobs", job_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule
